// File: rtl/fa_bist_checker.sv
// Built-in self-test engine for a 1-bit full adder: walks all eight {A,B,Cin}
// vectors, holds each for a settle window, then checks Sum/Cout against golden values.
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             tv_a,
  output logic             tv_b,
  output logic             tv_cin,
  input  logic             dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a level sampled only in IDLE or DONE; busy/done are
  // levels with no ready back-pressure, done holds until the next start or rst.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       start_run;
  logic       exp_sum;
  logic       exp_cout;
  logic       mismatch;

  // The vector register drives the adder directly, so tv_* are registered and
  // naturally hold 3'b111 once the walk terminates.
  assign tv_a   = vec[2];
  assign tv_b   = vec[1];
  assign tv_cin = vec[0];

  assign exp_sum   = tv_a ^ tv_b ^ tv_cin;
  assign exp_cout  = (tv_a & tv_b) | (tv_a & tv_cin) | (tv_b & tv_cin);
  assign mismatch  = (dut_sum != exp_sum) || (dut_cout != exp_cout);
  assign start_run = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_SETTLE;
      S_SETTLE:       if (cnt == 4'd0) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (vec == 3'd7) ? S_DONE : S_SETTLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_SETTLE) || (state == S_CHECK);
    done      = (state == S_DONE);
    pass      = (state == S_DONE) && (err_count == '0);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec              <= 3'd0;
      cnt              <= 4'd0;
      err_count        <= '0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else if (start_run) begin
      vec              <= 3'd0;
      cnt              <= SETTLE_LOAD;
      err_count        <= '0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else if (state == S_SETTLE) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end else if (state == S_CHECK) begin
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
        if (!first_fail_valid) begin
          first_fail_vec   <= vec;
          first_fail_valid <= 1'b1;
        end
      end
      // Vector 7 is terminal; the walk never wraps back to 0.
      if (vec != 3'd7) begin
        vec <= vec + 3'd1;
        cnt <= SETTLE_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: three instances (defaults, ERR_W=2,
// SETTLE_CYCLES=1), each fed by a full-adder model with selectable faults.
module tb_fa_bist_checker;

  logic       clk;
  logic       rst;
  logic       start    [3];
  int         mode     [3];  // 0 good, 1 sum stuck-0, 2 cout inverted, 3 sum two flops late
  logic [2:0] tv_w     [3];
  logic       busy_w   [3];
  logic       done_w   [3];
  logic       pass_w   [3];
  logic [3:0] err_w    [3];
  logic [2:0] ffv_w    [3];
  logic       ffval_w  [3];
  logic [1:0] state_w  [3];

  int nchk;
  int nerr;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and adder models ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GS = (g == 2) ? 1 : 2;
    localparam int GE = (g == 1) ? 2 : 4;
    logic          a, b, c, sum_ok, cout_ok, d1, d2, sum_in, cout_in;
    logic [GE-1:0] err_l;

    assign sum_ok  = a ^ b ^ c;
    assign cout_ok = (a & b) | (a & c) | (b & c);
    assign tv_w[g] = {a, b, c};
    assign err_w[g] = 4'(err_l);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d1 <= 1'b0;
        d2 <= 1'b0;
      end else begin
        d1 <= sum_ok;
        d2 <= d1;
      end
    end

    always_comb begin
      sum_in  = sum_ok;
      cout_in = cout_ok;
      case (mode[g])
        1:       sum_in  = 1'b0;
        2:       cout_in = ~cout_ok;
        3:       sum_in  = d2;
        default: sum_in  = sum_ok;
      endcase
    end

    fa_bist_checker #(.SETTLE_CYCLES(GS), .ERR_W(GE)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start[g]),
      .tv_a             (a),
      .tv_b             (b),
      .tv_cin           (c),
      .dut_sum          (sum_in),
      .dut_cout         (cout_in),
      .busy             (busy_w[g]),
      .done             (done_w[g]),
      .pass             (pass_w[g]),
      .err_count        (err_l),
      .first_fail_vec   (ffv_w[g]),
      .first_fail_valid (ffval_w[g]),
      .state_dbg        (state_w[g])
    );
  end

  // ---------------- driver tasks ----------------
  // Leaves the caller at the falling edge just after the start edge (edge 0).
  task automatic pulse_start(input int w);
    @(negedge clk);
    start[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[w] = 1'b0;
  endtask

  // Counts busy cycles and checks tv_* against the expected walk; optionally
  // raises start so that it is sampled at edge extra_at.
  task automatic track(input int w, input int s, input int extra_at,
                       output int cycles, output int tv_errs);
    cycles  = 0;
    tv_errs = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_w[w]) break;
      if (tv_w[w] !== 3'(cycles / (s + 1))) tv_errs++;
      cycles++;
      start[w] = (cycles == extra_at);
      @(negedge clk);
    end
    start[w] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    nchk++;
    if ({busy_w[0], done_w[0], pass_w[0], ffval_w[0]} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 0000", {busy_w[0], done_w[0], pass_w[0], ffval_w[0]});
    end
    nchk++;
    if ({tv_w[0], ffv_w[0], err_w[0], state_w[0]} !== 12'h000) begin
      nerr++;
      $display("FAIL reset_values: got tv=%b ffv=%b err=%0d state=%0d want all 0",
               tv_w[0], ffv_w[0], err_w[0], state_w[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_correct();
    int cyc, tve;
    mode[0] = 0;
    pulse_start(0);
    track(0, 2, -1, cyc, tve);
    nchk++;
    if (cyc !== 24) begin nerr++; $display("FAIL correct_busy_len: got %0d want 24", cyc); end
    nchk++;
    if (tve !== 0) begin nerr++; $display("FAIL correct_tv_walk: got %0d bad cycles want 0", tve); end
    nchk++;
    if ({done_w[0], pass_w[0], ffval_w[0], tv_w[0]} !== 6'b110111) begin
      nerr++;
      $display("FAIL correct_result: got done/pass/ffval/tv=%b want 110111",
               {done_w[0], pass_w[0], ffval_w[0], tv_w[0]});
    end
    nchk++;
    if (err_w[0] !== 4'd0) begin nerr++; $display("FAIL correct_err: got %0d want 0", err_w[0]); end
  endtask

  task automatic test_sum_stuck();
    int cyc, tve;
    mode[0] = 1;
    pulse_start(0);
    track(0, 2, -1, cyc, tve);
    nchk++;
    if (err_w[0] !== 4'd4) begin nerr++; $display("FAIL stuck_err: got %0d want 4", err_w[0]); end
    nchk++;
    if ({ffval_w[0], ffv_w[0]} !== 4'b1001) begin
      nerr++;
      $display("FAIL stuck_first: got valid/vec=%b want 1001", {ffval_w[0], ffv_w[0]});
    end
    nchk++;
    if ({done_w[0], pass_w[0]} !== 2'b10) begin
      nerr++;
      $display("FAIL stuck_pass: got done/pass=%b want 10", {done_w[0], pass_w[0]});
    end
  endtask

  task automatic test_start_handling();
    int cyc, tve;
    mode[0] = 0;
    pulse_start(0);  // from DONE holding err=4
    nchk++;
    if ({busy_w[0], done_w[0], ffval_w[0], err_w[0]} !== 7'b1000000) begin
      nerr++;
      $display("FAIL restart_clear: got busy/done/ffval/err=%b want 1000000",
               {busy_w[0], done_w[0], ffval_w[0], err_w[0]});
    end
    track(0, 2, 10, cyc, tve);
    nchk++;
    if (cyc !== 24) begin nerr++; $display("FAIL busy_start_ignored: got %0d want 24", cyc); end
    nchk++;
    if ({done_w[0], pass_w[0]} !== 2'b11 || tve !== 0) begin
      nerr++;
      $display("FAIL restart_result: got done/pass=%b tv_errs=%0d want 11 and 0",
               {done_w[0], pass_w[0]}, tve);
    end
  endtask

  task automatic test_saturation();
    int cyc, tve;
    pulse_start(1);
    track(1, 2, -1, cyc, tve);
    nchk++;
    if (err_w[1] !== 4'd3) begin nerr++; $display("FAIL sat_err: got %0d want 3", err_w[1]); end
    nchk++;
    if ({ffval_w[1], ffv_w[1], pass_w[1], done_w[1]} !== 6'b100001) begin
      nerr++;
      $display("FAIL sat_first: got ffval/ffv/pass/done=%b want 100001",
               {ffval_w[1], ffv_w[1], pass_w[1], done_w[1]});
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, tve;
    mode[0] = 1;
    pulse_start(0);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nchk++;
    if ({busy_w[0], done_w[0], pass_w[0], ffval_w[0], tv_w[0], ffv_w[0], err_w[0], state_w[0]} !== 16'h0) begin
      nerr++;
      $display("FAIL mid_reset: got busy=%b done=%b tv=%b ffv=%b err=%0d state=%0d want all 0",
               busy_w[0], done_w[0], tv_w[0], ffv_w[0], err_w[0], state_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    mode[0] = 0;
    pulse_start(0);
    track(0, 2, -1, cyc, tve);
    nchk++;
    if (cyc !== 24 || tve !== 0 || pass_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_run: got cycles=%0d tv_errs=%0d pass=%b want 24 0 1", cyc, tve, pass_w[0]);
    end
  endtask

  task automatic test_settle_window();
    int cyc, tve;
    mode[2] = 0;
    pulse_start(2);
    track(2, 1, -1, cyc, tve);
    nchk++;
    if (cyc !== 16 || tve !== 0) begin
      nerr++;
      $display("FAIL s1_len: got cycles=%0d tv_errs=%0d want 16 0", cyc, tve);
    end
    nchk++;
    if (pass_w[2] !== 1'b1) begin nerr++; $display("FAIL s1_pass: got %b want 1", pass_w[2]); end
    mode[2] = 3;
    pulse_start(2);
    track(2, 1, -1, cyc, tve);
    nchk++;
    if ({done_w[2], pass_w[2]} !== 2'b10) begin
      nerr++;
      $display("FAIL s1_late_sum: got done/pass=%b want 10", {done_w[2], pass_w[2]});
    end
    mode[0] = 3;
    pulse_start(0);
    track(0, 2, -1, cyc, tve);
    nchk++;
    if ({done_w[0], pass_w[0]} !== 2'b11 || err_w[0] !== 4'd0) begin
      nerr++;
      $display("FAIL s2_late_sum: got done/pass=%b err=%0d want 11 0", {done_w[0], pass_w[0]}, err_w[0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    mode[0] = 0;
    mode[1] = 2;
    mode[2] = 0;
    test_reset();
    test_correct();
    test_sum_stuck();
    test_start_handling();
    test_saturation();
    test_reset_mid_run();
    test_settle_window();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
